// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: response encodings and the shared request/response bus interface
package bus_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface bus_if;
  import bus_pkg::*;
  logic valid;
  logic ready;
  logic wr_en;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  resp_t resp;
  modport master(output valid, wr_en, addr, wdata, input ready, rdata, resp);
  modport slave(input valid, wr_en, addr, wdata, output ready, rdata, resp);
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin bus arbiter with per-transaction timeout
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  bus_if.slave       m0,
  bus_if.slave       m1,
  bus_if.master      s,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  state_t state, nxt;
  logic last, last_nxt, gnt, sel, mv, to, fin;
  logic [7:0] tcnt, tcnt_nxt;
  assign gnt = state != IDLE;
  assign sel = state == GRANT1;
  assign mv = sel ? m1.valid : m0.valid;
  // a same-cycle s.ready beats the timeout; a dropped valid is an abandon, not a timeout
  assign to = gnt && mv && !s.ready && tcnt == TLAST;
  assign fin = gnt && (s.ready || to);
  always_comb begin
    nxt = state;
    if (!gnt) nxt = m0.valid && (!m1.valid || last) ? GRANT0 : m1.valid ? GRANT1 : IDLE;
    else if (fin || !mv) nxt = IDLE;
    last_nxt = fin ? sel : last;
    tcnt_nxt = gnt && nxt != IDLE ? (&tcnt ? tcnt : tcnt + 8'd1) : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      tcnt <= '0;
    end else begin
      state <= nxt;
      last <= last_nxt;
      tcnt <= tcnt_nxt;
    end
  end
  assign s.valid = gnt && mv && !to;
  assign s.wr_en = gnt && (sel ? m1.wr_en : m0.wr_en);
  assign s.addr = !gnt ? '0 : sel ? m1.addr : m0.addr;
  assign s.wdata = !gnt ? '0 : sel ? m1.wdata : m0.wdata;
  assign m0.ready = state == GRANT0 && (s.ready || to);
  assign m0.rdata = state == GRANT0 && !to ? s.rdata : '0;
  assign m0.resp = state != GRANT0 ? RESP_OKAY : to ? RESP_SLVERR : s.resp;
  assign m1.ready = sel && (s.ready || to);
  assign m1.rdata = sel && !to ? s.rdata : '0;
  assign m1.resp = !sel ? RESP_OKAY : to ? RESP_SLVERR : s.resp;
  assign grant = {sel, state == GRANT0};
  assign busy = |grant;
  assign timeout_err = to;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scenario tasks plus a response scoreboard for bus_arbiter_rr (TIMEOUT=4)
module tb_bus_arbiter_rr;
  import bus_pkg::*;
  typedef struct {
    logic       id;
    logic [7:0] rdata;
    resp_t      resp;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant;
  logic busy, timeout_err;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  bus_if m0_if ();
  bus_if m1_if ();
  bus_if s_if ();
  bus_arbiter_rr #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every master-side ready must match the oldest expected response
  always @(negedge clk) begin
    if (m0_if.ready || m1_if.ready) begin
      exp_t e;
      logic [10:0] got;
      checks++;
      got = m1_if.ready ? {m0_if.ready, m1_if.rdata, m1_if.resp} : {1'b0, m0_if.rdata, m0_if.resp};
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready t=%0t m0.ready=%b m1.ready=%b", $time, m0_if.ready, m1_if.ready);
      end else begin
        e = q.pop_front();
        if ({m1_if.ready, got} !== {e.id, 1'b0, e.rdata, e.resp}) begin
          failures++;
          $display("FAIL response t=%0t got id=%b both=%b rdata=%h resp=%b exp id=%b rdata=%h resp=%b",
                   $time, m1_if.ready, got[10], got[9:2], got[1:0], e.id, e.rdata, e.resp);
        end
      end
    end
  end

  task automatic test_reset;
    m0_if.valid = 1; m1_if.valid = 1;
    m0_if.addr = 8'hAA; m0_if.wdata = 8'h55; m0_if.wr_en = 1;
    m1_if.addr = 8'h66; m1_if.wdata = 8'h99;
    s_if.rdata = 8'hEE; s_if.resp = RESP_SLVERR;
    rst_n = 0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if ({grant, busy, timeout_err, s_if.valid, s_if.wr_en, s_if.addr, s_if.wdata} !== 22'd0) begin
      failures++;
      $display("FAIL reset_ctrl got grant=%b busy=%b terr=%b sv=%b we=%b addr=%h wdata=%h exp all 0",
               grant, busy, timeout_err, s_if.valid, s_if.wr_en, s_if.addr, s_if.wdata);
    end
    checks++;
    if ({m0_if.ready, m0_if.rdata, m0_if.resp, m1_if.ready, m1_if.rdata, m1_if.resp} !== {1'b0, 8'h00, RESP_OKAY, 1'b0, 8'h00, RESP_OKAY}) begin
      failures++;
      $display("FAIL reset_resp got m0=%b/%h/%b m1=%b/%h/%b exp 0/00/okay", m0_if.ready, m0_if.rdata, m0_if.resp,
               m1_if.ready, m1_if.rdata, m1_if.resp);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({grant, busy} !== 3'b011) begin
      failures++;
      $display("FAIL reset_first_grant got grant=%b busy=%b exp 01/1", grant, busy);
    end
    tick;
    m0_if.valid = 0; m1_if.valid = 0; m0_if.wr_en = 0;
    s_if.resp = RESP_OKAY; s_if.rdata = 0;
    tick;
  endtask

  task automatic test_single_read;
    m1_if.addr = 8'h45; m1_if.wr_en = 0; m1_if.valid = 1;
    q.push_back('{1'b1, 8'hA5, RESP_OKAY});
    @(negedge clk);
    checks++;
    if ({grant, s_if.addr} !== {2'b00, 8'h00}) begin
      failures++;
      $display("FAIL read_idle got grant=%b addr=%h exp 00/00", grant, s_if.addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i == 2) begin s_if.ready = 1; s_if.rdata = 8'hA5; s_if.resp = RESP_OKAY; end
      @(negedge clk);
      checks++;
      if ({grant, s_if.valid, s_if.addr, m0_if.ready, m1_if.ready} !== {2'b10, 1'b1, 8'h45, 1'b0, i == 2}) begin
        failures++;
        $display("FAIL read_cycle%0d got grant=%b sv=%b addr=%h m0r=%b m1r=%b exp 10/1/45/0/%b",
                 i, grant, s_if.valid, s_if.addr, m0_if.ready, m1_if.ready, i == 2);
      end
    end
    checks++;
    if ({m1_if.rdata, m1_if.resp} !== {8'hA5, RESP_OKAY}) begin
      failures++;
      $display("FAIL read_data got rdata=%h resp=%b exp a5/okay", m1_if.rdata, m1_if.resp);
    end
    tick;
    m1_if.valid = 0; s_if.ready = 0; s_if.rdata = 0;
    @(negedge clk);
    checks++;
    if ({grant, s_if.addr, m0_if.ready} !== 11'd0) begin
      failures++;
      $display("FAIL read_after got grant=%b addr=%h m0r=%b exp 00/00/0", grant, s_if.addr, m0_if.ready);
    end
    tick;
  endtask

  task automatic test_contention;
    m0_if.addr = 8'h11; m1_if.addr = 8'h22;
    m0_if.valid = 1; m1_if.valid = 1;
    s_if.ready = 1; s_if.rdata = 8'h3C;
    for (int k = 0; k < 6; k++) q.push_back('{k[0], 8'h3C, RESP_OKAY});
    for (int i = 0; i < 12; i++) begin
      logic [1:0] eg;
      eg = i[0] ? (i[1] ? 2'b10 : 2'b01) : 2'b00;
      @(negedge clk);
      checks++;
      if (grant !== eg) begin
        failures++;
        $display("FAIL contention_step%0d got grant=%b exp %b", i, grant, eg);
      end
      tick;
    end
    m0_if.valid = 0; m1_if.valid = 0; s_if.ready = 0; s_if.rdata = 0;
    tick;
  endtask

  task automatic test_timeout;
    m0_if.addr = 8'h10; m0_if.wdata = 8'h77; m0_if.wr_en = 1; m0_if.valid = 1;
    s_if.rdata = 8'hFF; s_if.resp = RESP_OKAY;
    q.push_back('{1'b0, 8'h00, RESP_SLVERR});
    for (int i = 0; i < 4; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if ({grant, timeout_err, s_if.valid, m0_if.ready} !== {2'b01, i == 3, i != 3, i == 3}) begin
        failures++;
        $display("FAIL timeout_cycle%0d got grant=%b terr=%b sv=%b m0r=%b", i, grant, timeout_err, s_if.valid, m0_if.ready);
      end
    end
    checks++;
    if ({m0_if.resp, m0_if.rdata} !== {RESP_SLVERR, 8'h00}) begin
      failures++;
      $display("FAIL timeout_resp got resp=%b rdata=%h exp slverr/00", m0_if.resp, m0_if.rdata);
    end
    tick;
    m0_if.valid = 0;
    @(negedge clk);
    checks++;
    if ({grant, timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_idle got grant=%b terr=%b exp 00/0", grant, timeout_err);
    end
    tick;
    m0_if.valid = 1;
    q.push_back('{1'b0, 8'h5A, RESP_OKAY});
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 3) begin s_if.ready = 1; s_if.rdata = 8'h5A; end
      @(negedge clk);
      checks++;
      if ({grant, timeout_err, s_if.valid, s_if.wr_en, s_if.wdata, m0_if.ready} !== {2'b01, 1'b0, 1'b1, 1'b1, 8'h77, i == 3}) begin
        failures++;
        $display("FAIL tie_cycle%0d got grant=%b terr=%b sv=%b we=%b wdata=%h m0r=%b", i, grant, timeout_err,
                 s_if.valid, s_if.wr_en, s_if.wdata, m0_if.ready);
      end
    end
    tick;
    m0_if.valid = 0; m0_if.wr_en = 0; s_if.ready = 0; s_if.rdata = 0;
    tick;
  endtask

  task automatic test_abandon;
    m1_if.addr = 8'h33; m1_if.valid = 1;
    tick;
    @(negedge clk);
    checks++;
    if ({grant, s_if.valid} !== 3'b101) begin
      failures++;
      $display("FAIL abandon_grant got grant=%b sv=%b exp 10/1", grant, s_if.valid);
    end
    tick;
    m1_if.valid = 0;
    @(negedge clk);
    checks++;
    if ({grant, s_if.valid, m1_if.ready} !== 4'b1000) begin
      failures++;
      $display("FAIL abandon_drop got grant=%b sv=%b m1r=%b exp 10/0/0", grant, s_if.valid, m1_if.ready);
    end
    tick;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      failures++;
      $display("FAIL abandon_idle got grant=%b exp 00", grant);
    end
    m0_if.valid = 1; m1_if.valid = 1;
    s_if.ready = 1; s_if.rdata = 8'hC3;
    q.push_back('{1'b1, 8'hC3, RESP_OKAY});
    tick;
    @(negedge clk);
    checks++;
    if ({grant, m1_if.ready} !== 3'b101) begin
      failures++;
      $display("FAIL abandon_rewin got grant=%b m1r=%b exp 10/1", grant, m1_if.ready);
    end
    tick;
    m0_if.valid = 0; m1_if.valid = 0; s_if.ready = 0; s_if.rdata = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    m1_if.valid = 1;
    tick;
    @(negedge clk);
    checks++;
    if ({grant, s_if.valid} !== 3'b101) begin
      failures++;
      $display("FAIL rstmid_grant got grant=%b sv=%b exp 10/1", grant, s_if.valid);
    end
    rst_n = 0;
    tick;
    @(negedge clk);
    checks++;
    if ({grant, s_if.valid, m1_if.ready, busy} !== 5'b00000) begin
      failures++;
      $display("FAIL rstmid_drop got grant=%b sv=%b m1r=%b busy=%b exp 00/0/0/0", grant, s_if.valid, m1_if.ready, busy);
    end
    m1_if.valid = 0;
    rst_n = 1;
    tick;
  endtask

  initial begin
    m0_if.valid = 0; m0_if.wr_en = 0; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.valid = 0; m1_if.wr_en = 0; m1_if.addr = 0; m1_if.wdata = 0;
    s_if.ready = 0; s_if.rdata = 0; s_if.resp = RESP_OKAY;
    test_reset;
    test_single_read;
    test_contention;
    test_timeout;
    test_abandon;
    test_reset_mid;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending responses exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
